// File: rtl/wb_master_pipelined_if.sv
// if_wb: Wishbone pipelined bus between the block-transfer master and the RAM slave.
interface if_wb (
   input logic clk,
   input logic rst
);
   logic        cyc, stb, we, stall, ack;
   logic [15:0] adr, dat_i, dat_o;
   modport master (input clk, rst, stall, ack, dat_o, output cyc, stb, we, adr, dat_i);
   modport slave  (input clk, rst, cyc, stb, we, adr, dat_i, output stall, ack, dat_o);
endinterface

// File: rtl/wb_master_pipelined.sv
// wb_master_pipelined: issues one command as a single cyc burst of pipelined stb beats,
// keeping at most MAX_OUTSTANDING accepted-but-unacked beats on the bus.
module wb_master_pipelined #(
   parameter int MAX_OUTSTANDING = 4
) (
   if_wb.master        wb,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [15:0] cmd_adr,
   input  logic [15:0] cmd_len,
   input  logic [15:0] wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
   localparam logic [4:0] MAX_O = 5'(MAX_OUTSTANDING);
   state_t      state_q, state_d;
   logic        we_q, we_d, stb_q, stb_d, bwe_q, bwe_d;
   logic        rd_valid_q, rd_valid_d, done_q, done_d;
   logic [15:0] nxt_q, nxt_d, rem_q, rem_d, adr_q, adr_d, dat_q, dat_d, rd_data_q, rd_data_d;
   logic [3:0]  infl_q, infl_d;
   logic        start, accept, ack_ok, load, src_we;
   logic [15:0] src_adr, src_rem;
   always_comb begin
      start      = state_q == IDLE && cmd_valid && cmd_len != 16'd0;
      accept     = stb_q && !wb.stall;
      ack_ok     = wb.ack && infl_q != 4'd0;
      infl_d     = infl_q + 4'(accept) - 4'(ack_ok);
      src_we     = start ? cmd_we : we_q;
      src_adr    = start ? cmd_adr : nxt_q;
      src_rem    = start ? cmd_len : rem_q;
      // the handshake edge itself stages the first beat, so cyc and stb rise together
      load       = src_rem != 16'd0 && (!stb_q || accept) && (!src_we || wr_valid)
                   && {1'b0, infl_d} < MAX_O;
      wr_ready   = load && src_we;
      we_d       = src_we;
      nxt_d      = load ? src_adr + 16'd1 : src_adr;
      rem_d      = load ? src_rem - 16'd1 : src_rem;
      stb_d      = load || (stb_q && wb.stall);
      adr_d      = load ? src_adr : adr_q;
      dat_d      = load ? wr_data : dat_q;
      bwe_d      = load ? src_we : bwe_q;
      rd_valid_d = ack_ok && !we_q;
      rd_data_d  = rd_valid_d ? wb.dat_o : rd_data_q;
      state_d    = start ? BUSY
                 : (state_q == BUSY && rem_q == 16'd0 && accept) ? DRAIN
                 : (state_q == DRAIN && infl_d == 4'd0) ? IDLE : state_q;
      done_d     = (state_q == IDLE && cmd_valid && cmd_len == 16'd0)
                 || (state_q == DRAIN && infl_d == 4'd0);
   end
   always_ff @(posedge wb.clk) begin
      if (wb.rst) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         stb_q      <= 1'b0;
         bwe_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         nxt_q      <= 16'd0;
         rem_q      <= 16'd0;
         adr_q      <= 16'd0;
         dat_q      <= 16'd0;
         rd_data_q  <= 16'd0;
         infl_q     <= 4'd0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         stb_q      <= stb_d;
         bwe_q      <= bwe_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         nxt_q      <= nxt_d;
         rem_q      <= rem_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         rd_data_q  <= rd_data_d;
         infl_q     <= infl_d;
      end
   end
   assign wb.cyc    = state_q != IDLE;
   assign wb.stb    = stb_q;
   assign wb.we     = bwe_q;
   assign wb.adr    = adr_q;
   assign wb.dat_i  = dat_q;
   assign cmd_ready = state_q == IDLE;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign done      = done_q;
endmodule

// File: tb/tb_wb_master_pipelined.sv
// tb_wb_master_pipelined: directed command table plus hand sequences for reset, underflow and a
// single-outstanding instance, against a behavioural pipelined RAM slave with optional wait cycles.
module tb_wb_master_pipelined;
   typedef struct {
      logic        we;
      logic [15:0] adr;
      logic [15:0] len;
      logic [15:0] dbase;
      int          ws;
      int          ga;
      int          gl;
      int          lat;
   } vec_t;
   typedef struct {
      int          c;
      logic [15:0] adr;
      logic        we;
      logic [15:0] dat;
   } rec_t;

   logic        clk, rst;
   logic        cmd_valid0, cmd_we0, wr_valid0, cmd_ready0, wr_ready0, rd_valid0, done0;
   logic [15:0] cmd_adr0, cmd_len0, wr_data0, rd_data0;
   logic        cmd_valid1, cmd_we1, wr_valid1, cmd_ready1, wr_ready1, rd_valid1, done1;
   logic [15:0] cmd_adr1, cmd_len1, wr_data1, rd_data1;

   if_wb b0 (.clk(clk), .rst(rst));
   if_wb b1 (.clk(clk), .rst(rst));

   wb_master_pipelined #(.MAX_OUTSTANDING(4)) u_dut0 (
      .wb(b0), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_we(cmd_we0),
      .cmd_adr(cmd_adr0), .cmd_len(cmd_len0), .wr_data(wr_data0), .wr_valid(wr_valid0),
      .wr_ready(wr_ready0), .rd_data(rd_data0), .rd_valid(rd_valid0), .done(done0));
   wb_master_pipelined #(.MAX_OUTSTANDING(1)) u_dut1 (
      .wb(b1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_we(cmd_we1),
      .cmd_adr(cmd_adr1), .cmd_len(cmd_len1), .wr_data(wr_data1), .wr_valid(wr_valid1),
      .wr_ready(wr_ready1), .rd_data(rd_data1), .rd_valid(rd_valid1), .done(done1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // slave 0: RAM with ws0 stall cycles per beat, ack one cycle after accept
   logic [15:0] mem0 [65536];
   int          ws0 = 0;
   int          wcnt0;
   assign b0.stall = b0.cyc && b0.stb && wcnt0 < ws0;
   always @(posedge clk) begin
      if (rst) begin
         b0.ack <= 1'b0;
         wcnt0  <= 0;
      end else begin
         b0.ack <= b0.cyc && b0.stb && !b0.stall;
         if (b0.cyc && b0.stb && !b0.stall) begin
            wcnt0 <= 0;
            if (b0.we) mem0[b0.adr] <= b0.dat_i;
            else b0.dat_o <= mem0[b0.adr];
         end else if (b0.cyc && b0.stb) wcnt0 <= wcnt0 + 1;
      end
   end

   // slave 1: zero-wait, write-only sink
   assign b1.stall = 1'b0;
   assign b1.dat_o = 16'h0000;
   always @(posedge clk) b1.ack <= !rst && b1.cyc && b1.stb;

   int          nvec = 0, nfail = 0, cnt = 0;
   rec_t        acc0[$], rdq0[$], acc1[$];
   int          nack0 = 0, ndone0 = 0, done_cyc0 = 0, ncyc0 = 0, outst0 = 0, maxinf0 = 0;
   int          stallv0 = 0, cycdrop0 = 0, ndone1 = 0, done_cyc1 = 0, outst1 = 0, maxinf1 = 0;
   int          widx0 = 0, widx1 = 0;
   logic [15:0] wbase0 = 16'h0, wbase1 = 16'h0, padr0 = 16'h0, pdat0 = 16'h0;
   logic        pstall0 = 1'b0, pwe0 = 1'b0, rdy0_s = 1'b0;
   vec_t        vt [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // one clock: observe at negedge, step past posedge, then advance the write-data sources
   task automatic tick();
      logic t0, t1, a0, a1;
      @(negedge clk);
      rdy0_s = cmd_ready0;
      a0 = b0.cyc && b0.stb && !b0.stall;
      a1 = b1.cyc && b1.stb && !b1.stall;
      if (pstall0 && (!b0.stb || b0.adr != padr0 || b0.we != pwe0 || b0.dat_i != pdat0)) stallv0++;
      pstall0 = b0.stb && b0.stall && !rst;
      padr0 = b0.adr; pwe0 = b0.we; pdat0 = b0.dat_i;
      if (!b0.cyc && outst0 != 0) cycdrop0++;
      if (b0.cyc) ncyc0++;
      if (a0) acc0.push_back('{cnt, b0.adr, b0.we, b0.dat_i});
      if (b0.ack) nack0++;
      if (rd_valid0) rdq0.push_back('{cnt, 16'h0, 1'b0, rd_data0});
      if (done0) begin ndone0++; done_cyc0 = cnt; end
      outst0 = rst ? 0 : outst0 + (a0 ? 1 : 0) - ((b0.ack && outst0 > 0) ? 1 : 0);
      if (outst0 > maxinf0) maxinf0 = outst0;
      if (a1) acc1.push_back('{cnt, b1.adr, b1.we, b1.dat_i});
      if (done1) begin ndone1++; done_cyc1 = cnt; end
      outst1 = rst ? 0 : outst1 + (a1 ? 1 : 0) - ((b1.ack && outst1 > 0) ? 1 : 0);
      if (outst1 > maxinf1) maxinf1 = outst1;
      t0 = wr_valid0 && wr_ready0;
      t1 = wr_valid1 && wr_ready1;
      @(posedge clk);
      cnt++;
      #1;
      if (t0) begin widx0++; wr_data0 = wbase0 + 16'(widx0); end
      if (t1) begin widx1++; wr_data1 = wbase1 + 16'(widx1); end
   endtask

   task automatic run_cmd(input vec_t v, input int id);
      int          c0, a0, r0, d0, k0, n0, gc, ne;
      logic [15:0] ea, ed;
      rec_t        r;
      ws0 = v.ws;
      a0 = acc0.size(); r0 = rdq0.size(); d0 = ndone0; k0 = nack0; n0 = ncyc0; gc = 0;
      wbase0 = v.dbase; widx0 = 0; wr_data0 = v.dbase; wr_valid0 = v.we;
      cmd_valid0 = 1'b1; cmd_we0 = v.we; cmd_adr0 = v.adr; cmd_len0 = v.len;
      c0 = cnt;
      tick();
      cmd_valid0 = 1'b0;
      chk($sformatf("v%0d_cmd_ready", id), 32'(rdy0_s), 32'd1);
      for (int k = 0; k < 200 && ndone0 == d0; k++) begin
         if (v.we && widx0 == v.ga && gc < v.gl) begin
            wr_valid0 = 1'b0;
            gc++;
         end else wr_valid0 = v.we;
         tick();
      end
      wr_valid0 = 1'b0;
      repeat (2) tick();
      ne = v.we ? 0 : int'(v.len);
      chk($sformatf("v%0d_done_count", id), ndone0 - d0, 1);
      chk($sformatf("v%0d_done_lat", id), done_cyc0 - c0, v.lat);
      chk($sformatf("v%0d_cyc_cycles", id), ncyc0 - n0, v.lat - 1);
      chk($sformatf("v%0d_acks", id), nack0 - k0, int'(v.len));
      chk($sformatf("v%0d_beats", id), acc0.size() - a0, int'(v.len));
      chk($sformatf("v%0d_rd_count", id), rdq0.size() - r0, ne);
      for (int i = 0; i < int'(v.len) && a0 + i < acc0.size(); i++) begin
         r = acc0[a0 + i];
         ea = v.adr + 16'(i);
         ed = v.dbase + 16'(i);
         chk($sformatf("v%0d_adr%0d", id, i), r.adr, ea);
         chk($sformatf("v%0d_we%0d", id, i), 32'(r.we), 32'(v.we));
         chk($sformatf("v%0d_acc_cyc%0d", id, i), r.c - c0,
             1 + i * (v.ws + 1) + v.ws + (i >= v.ga ? v.gl : 0));
         if (v.we) chk($sformatf("v%0d_wdat%0d", id, i), r.dat, ed);
      end
      for (int i = 0; i < ne && r0 + i < rdq0.size(); i++) begin
         r = rdq0[r0 + i];
         ed = v.dbase + 16'(i);
         chk($sformatf("v%0d_rdat%0d", id, i), r.dat, ed);
         chk($sformatf("v%0d_rd_cyc%0d", id, i), r.c - c0, 3 + i * (v.ws + 1) + v.ws);
      end
   endtask

   initial begin
      int          c0, d0, k0, r0, a1;
      logic [15:0] ed;
      //          we    adr       len     dbase     ws ga  gl lat
      vt[0]  = '{1'b1, 16'h1234, 16'd4, 16'hA000, 0, 99, 0, 6};
      vt[1]  = '{1'b0, 16'h1234, 16'd4, 16'hA000, 0, 99, 0, 6};
      vt[2]  = '{1'b1, 16'hFFFE, 16'd3, 16'hB000, 0, 99, 0, 5};
      vt[3]  = '{1'b0, 16'hFFFE, 16'd3, 16'hB000, 0, 99, 0, 5};
      vt[4]  = '{1'b0, 16'h1234, 16'd4, 16'hA000, 2, 99, 0, 14};
      vt[5]  = '{1'b1, 16'h0040, 16'd2, 16'hD000, 2, 99, 0, 8};
      vt[6]  = '{1'b0, 16'h0040, 16'd2, 16'hD000, 0, 99, 0, 4};
      vt[7]  = '{1'b1, 16'h0200, 16'd6, 16'hE000, 0, 2,  3, 11};
      vt[8]  = '{1'b0, 16'h0200, 16'd6, 16'hE000, 0, 99, 0, 8};
      vt[9]  = '{1'b1, 16'h0020, 16'd0, 16'h0000, 0, 99, 0, 1};
      vt[10] = '{1'b1, 16'h0010, 16'd1, 16'hC000, 0, 99, 0, 3};
      vt[11] = '{1'b0, 16'h0010, 16'd1, 16'hC000, 0, 99, 0, 3};
      rst = 1'b1;
      cmd_valid0 = 1'b0; cmd_we0 = 1'b0; cmd_adr0 = 16'h0; cmd_len0 = 16'h0;
      wr_valid0 = 1'b0; wr_data0 = 16'h0;
      cmd_valid1 = 1'b0; cmd_we1 = 1'b0; cmd_adr1 = 16'h0; cmd_len1 = 16'h0;
      wr_valid1 = 1'b0; wr_data1 = 16'h0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_cyc", 32'(b0.cyc), 32'd0);
      chk("rst_stb", 32'(b0.stb), 32'd0);
      chk("rst_we", 32'(b0.we), 32'd0);
      chk("rst_adr", b0.adr, 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid0), 32'd0);
      chk("rst_rd_data", rd_data0, 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready0), 32'd1);
      for (int i = 0; i < 12; i++) run_cmd(vt[i], i);

      // reset while a read burst is in flight, on the cycle of its third ack
      ws0 = 0; d0 = ndone0; k0 = nack0;
      cmd_valid0 = 1'b1; cmd_we0 = 1'b0; cmd_adr0 = 16'h0100; cmd_len0 = 16'd8;
      tick();
      cmd_valid0 = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_acks", nack0 - k0, 32'd3);
      chk("mid_rst_cyc", 32'(b0.cyc), 32'd0);
      chk("mid_rst_stb", 32'(b0.stb), 32'd0);
      chk("mid_rst_rd_valid", 32'(rd_valid0), 32'd0);
      chk("mid_rst_done", 32'(done0), 32'd0);
      chk("mid_rst_rd_data", rd_data0, 32'd0);
      r0 = rdq0.size();
      repeat (4) tick();
      chk("mid_rst_no_rd", rdq0.size() - r0, 32'd0);
      chk("mid_rst_no_done", ndone0 - d0, 32'd0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready0), 32'd1);
      run_cmd('{1'b1, 16'h0000, 16'd1, 16'h5A5A, 0, 99, 0, 3}, 20);
      chk("mid_rst_mem", mem0[0], 32'h5A5A);

      // single-outstanding instance: one beat every two cycles
      d0 = ndone1; a1 = acc1.size();
      wbase1 = 16'hF000; widx1 = 0; wr_data1 = 16'hF000; wr_valid1 = 1'b1;
      cmd_valid1 = 1'b1; cmd_we1 = 1'b1; cmd_adr1 = 16'h0300; cmd_len1 = 16'd4;
      c0 = cnt;
      tick();
      cmd_valid1 = 1'b0;
      for (int k = 0; k < 50 && ndone1 == d0; k++) tick();
      wr_valid1 = 1'b0;
      tick();
      chk("mo1_done_count", ndone1 - d0, 32'd1);
      chk("mo1_done_lat", done_cyc1 - c0, 32'd9);
      chk("mo1_beats", acc1.size() - a1, 32'd4);
      for (int i = 0; i < 4 && a1 + i < acc1.size(); i++) begin
         ed = 16'hF000 + 16'(i);
         chk($sformatf("mo1_acc_cyc%0d", i), acc1[a1 + i].c - c0, 1 + 2 * i);
         chk($sformatf("mo1_wdat%0d", i), acc1[a1 + i].dat, ed);
      end

      chk("max_inflight4", 32'(maxinf0 <= 4), 32'd1);
      chk("max_inflight1", 32'(maxinf1 <= 1), 32'd1);
      chk("stall_hold", stallv0, 32'd0);
      chk("cyc_continuity", cycdrop0, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
